mbist_data_cmp: RTL and testbench
=================================

// Module: mbist_data_cmp
// PURPOSE
//  Memory-side executor for the MBIST operation stream. Consumes the per-cycle op_read/op_write/op_invert
//  decode and the current address, drives the SRAM port, and compares read data against the expected
//  pattern after the SRAM read latency. Captures the first failing address, a saturating error count
//  and a sticky fail flag. Results are readable over the MBIST scan chain.
// PARAMETERS
//  BIST_ADDR_WD    9   address width
//  BIST_DATA_WD    32  data width
//  BIST_RD_LAT     1   SRAM read latency in cycles (mem_cs cycle to mem_rdata valid); legal 1..4
//  BIST_ERR_CNT_WD 4   error counter width
// PORTS
//  clk         in   1              clock
//  rst_n       in   1              asynchronous active-low reset
//  run         in   1              operation valid this cycle
//  op_read     in   1              read operation
//  op_write    in   1              write operation
//  op_invert   in   1              use inverted background pattern
//  bist_addr   in   BIST_ADDR_WD   operation address
//  bist_pat    in   BIST_DATA_WD   background data pattern
//  scan_shift  in   1              result chain shift enable
//  sdi         in   1              scan data in
//  sdo         out  1              scan data out
//  mem_cs      out  1              SRAM chip select, active high
//  mem_we      out  1              SRAM write enable, active high
//  mem_addr    out  BIST_ADDR_WD   SRAM address
//  mem_wdata   out  BIST_DATA_WD   SRAM write data
//  mem_rdata   in   BIST_DATA_WD   SRAM read data
//  err_pulse   out  1              one-cycle pulse per miscompare
//  bist_error  out  1              sticky fail flag
//  err_addr    out  BIST_ADDR_WD   address of first miscompare
//  err_cnt     out  BIST_ERR_CNT_WD  miscompare count, saturating
// BEHAVIOUR
//  Reset: all outputs and internal pipeline stages are 0. Reset takes effect at any time, including mid-test.
//  Issue stage (registered, 1 cycle):
//   - Condition: run=1 and scan_shift=0 and (op_read or op_write).
//     Next cycle: mem_cs=1, mem_addr=bist_addr, mem_wdata=exp.
//   - exp = op_invert ? ~bist_pat : bist_pat.
//   - mem_we = op_write & ~op_read. If both op_read and op_write are set, read wins and the write is suppressed.
//   - Otherwise mem_cs=0 and mem_we=0. mem_addr and mem_wdata hold their last value.
//  Compare pipeline:
//   - Each issued read pushes {valid, addr, exp} into a BIST_RD_LAT-deep shift register.
//   - The stage reaching depth BIST_RD_LAT is compared against mem_rdata in that cycle.
//   - miscompare = valid & (mem_rdata != exp); any bit difference counts.
//  Error capture (registered, 1 cycle after compare):
//   - err_pulse=1 for exactly one cycle.
//   - bist_error is set and stays set.
//   - err_addr is loaded only when bist_error was 0 (first fail wins).
//   - err_cnt increments, holding at all-ones (no wrap).
//   - Back-to-back miscompares each pulse and count.
//  Scan (scan_shift=1 has priority over run):
//   - Chain = {bist_error, err_cnt, err_addr}, length 1+BIST_ERR_CNT_WD+BIST_ADDR_WD.
//   - Each cycle: sdo = chain LSB (err_addr[0]); chain shifts right; sdi enters the bist_error position.
//   - sdo is combinational from chain[0].
//   - During scan: mem_cs=0, and all compare-pipeline valid bits are cleared, so in-flight reads are discarded and never flagged.
//   - err_pulse=0 during scan.
//   - A full-length shift of zeros clears the results.
//  Simultaneous miscompare and scan_shift: scan wins and the miscompare is dropped.
// TESTING
//  1. Write-then-read pass:
//     - Stimulus: pat=32'hA5A5A5A5, w@0x010 then r@0x010, mem model returns written data.
//     - Expect: mem_we=1 then 0; err_pulse never set; bist_error=0; err_cnt=0.
//  2. Invert path:
//     - Stimulus: op_invert=1, pat=32'h0000FFFF.
//     - Expect: mem_wdata=32'hFFFF0000; returned 32'hFFFF0000 passes; returned 32'h0000FFFF fails.
//  3. Latency check:
//     - Stimulus: BIST_RD_LAT=2, read @0x1F8, corrupted bit 5 presented exactly 2 cycles after mem_cs.
//     - Expect: err_pulse 1 cycle later; err_addr=9'h1F8; err_cnt=1.
//  4. First-fail / saturation:
//     - Stimulus: 20 consecutive failing reads, addrs 0x020..0x033.
//     - Expect: err_addr=9'h020; err_cnt=4'hF; bist_error=1.
//  5. Scan readout:
//     - Stimulus: after test 3 state, shift 14 cycles with sdi=0.
//     - Expect: sdo sequence = err_addr LSB-first, then err_cnt, then bist_error; all results 0 afterwards.
//  6. Scan/reset abort:
//     - Stimulus: issue a failing read, then assert scan_shift (or rst_n=0) before compare.
//     - Expect: no err_pulse; mem_cs=0; counters unchanged (scan) or 0 (reset).

Source files
------------

// File: rtl/mbist_data_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : mbist_data_cmp
//  Brief    : MBIST memory-side executor. Issues SRAM read/write operations,
//             compares read data against the expected pattern after the SRAM
//             read latency, and captures the first failing address, a
//             saturating miscompare count and a sticky fail flag. The results
//             are read out (and cleared) over a serial scan chain.
//  Revision : 1.0  initial release
// ============================================================================
module mbist_data_cmp #(
    parameter int BIST_ADDR_WD    = 9,
    parameter int BIST_DATA_WD    = 32,
    parameter int BIST_RD_LAT     = 1,
    parameter int BIST_ERR_CNT_WD = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic                       op_read,
    input  logic                       op_write,
    input  logic                       op_invert,
    input  logic [BIST_ADDR_WD-1:0]    bist_addr,
    input  logic [BIST_DATA_WD-1:0]    bist_pat,
    input  logic                       scan_shift,
    input  logic                       sdi,
    output logic                       sdo,
    output logic                       mem_cs,
    output logic                       mem_we,
    output logic [BIST_ADDR_WD-1:0]    mem_addr,
    output logic [BIST_DATA_WD-1:0]    mem_wdata,
    input  logic [BIST_DATA_WD-1:0]    mem_rdata,
    output logic                       err_pulse,
    output logic                       bist_error,
    output logic [BIST_ADDR_WD-1:0]    err_addr,
    output logic [BIST_ERR_CNT_WD-1:0] err_cnt
);

    localparam int                       CHAIN_WD = 1 + BIST_ERR_CNT_WD + BIST_ADDR_WD;
    localparam int                       LAST     = BIST_RD_LAT - 1;
    localparam logic [BIST_ERR_CNT_WD-1:0] CNT_ONE = {{(BIST_ERR_CNT_WD-1){1'b0}}, 1'b1};
    localparam logic [BIST_ERR_CNT_WD-1:0] CNT_MAX = {BIST_ERR_CNT_WD{1'b1}};

    // Issue stage
    logic                    issue;
    logic [BIST_DATA_WD-1:0] exp_pat;
    logic                    mem_cs_d,    mem_cs_q;
    logic                    mem_we_d,    mem_we_q;
    logic [BIST_ADDR_WD-1:0] mem_addr_d,  mem_addr_q;
    logic [BIST_DATA_WD-1:0] mem_wdata_d, mem_wdata_q;

    // Compare pipeline: stage 0 holds the read that was on the SRAM port last
    // cycle, so stage BIST_RD_LAT-1 lines up with its mem_rdata.
    logic [BIST_RD_LAT-1:0]  pv_d, pv_q;
    logic [BIST_ADDR_WD-1:0] pa_d [BIST_RD_LAT];
    logic [BIST_ADDR_WD-1:0] pa_q [BIST_RD_LAT];
    logic [BIST_DATA_WD-1:0] pe_d [BIST_RD_LAT];
    logic [BIST_DATA_WD-1:0] pe_q [BIST_RD_LAT];
    logic                    miscompare;

    // Result registers, which double as the scan chain
    logic                       err_pulse_d,  err_pulse_q;
    logic                       bist_error_d, bist_error_q;
    logic [BIST_ADDR_WD-1:0]    err_addr_d,   err_addr_q;
    logic [BIST_ERR_CNT_WD-1:0] err_cnt_d,    err_cnt_q;
    logic [CHAIN_WD-1:0]        chain;

    // Decode the operation into next SRAM port values; address/data hold when idle
    always_comb begin
        issue       = run & ~scan_shift & (op_read | op_write);
        exp_pat     = op_invert ? ~bist_pat : bist_pat;
        mem_cs_d    = issue;
        mem_we_d    = issue & op_write & ~op_read;
        mem_addr_d  = issue ? bist_addr : mem_addr_q;
        mem_wdata_d = issue ? exp_pat   : mem_wdata_q;
    end

    // Advance the compare pipeline; scan flushes every in-flight read
    always_comb begin
        pv_d    = '0;
        pv_d[0] = mem_cs_q & ~mem_we_q & ~scan_shift;
        pa_d[0] = mem_addr_q;
        pe_d[0] = mem_wdata_q;
        for (int i = 1; i < BIST_RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1] & ~scan_shift;
            pa_d[i] = pa_q[i-1];
            pe_d[i] = pe_q[i-1];
        end
        miscompare = pv_q[LAST] & (mem_rdata != pe_q[LAST]);
    end

    // Result update: scan shift has priority and drops a coincident miscompare
    always_comb begin
        chain        = {bist_error_q, err_cnt_q, err_addr_q};
        err_pulse_d  = 1'b0;
        bist_error_d = bist_error_q;
        err_addr_d   = err_addr_q;
        err_cnt_d    = err_cnt_q;
        if (scan_shift) begin
            {bist_error_d, err_cnt_d, err_addr_d} = {sdi, chain[CHAIN_WD-1:1]};
        end else if (miscompare) begin
            err_pulse_d  = 1'b1;
            bist_error_d = 1'b1;
            if (!bist_error_q) begin
                err_addr_d = pa_q[LAST];
            end
            if (err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            pv_q         <= '0;
            for (int i = 0; i < BIST_RD_LAT; i++) begin
                pa_q[i] <= '0;
                pe_q[i] <= '0;
            end
            err_pulse_q  <= 1'b0;
            bist_error_q <= 1'b0;
            err_addr_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            mem_cs_q     <= mem_cs_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            pv_q         <= pv_d;
            for (int i = 0; i < BIST_RD_LAT; i++) begin
                pa_q[i] <= pa_d[i];
                pe_q[i] <= pe_d[i];
            end
            err_pulse_q  <= err_pulse_d;
            bist_error_q <= bist_error_d;
            err_addr_q   <= err_addr_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign sdo        = chain[0];
    assign mem_cs     = mem_cs_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign err_pulse  = err_pulse_q;
    assign bist_error = bist_error_q;
    assign err_addr   = err_addr_q;
    assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mbist_data_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mbist_data_cmp
//  Brief    : Self-checking bench for mbist_data_cmp with a behavioural SRAM
//             and a transaction-level reference model of the results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mbist_data_cmp;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run, op_read, op_write, op_invert, scan_shift, sdi;
    logic [AW-1:0] bist_addr;
    logic [DW-1:0] bist_pat;
    logic          sdo, mem_cs, mem_we, err_pulse, bist_error;
    logic [AW-1:0] mem_addr, err_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] err_cnt;

    mbist_data_cmp #(
        .BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .BIST_RD_LAT(LAT), .BIST_ERR_CNT_WD(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .op_read(op_read), .op_write(op_write),
        .op_invert(op_invert), .bist_addr(bist_addr), .bist_pat(bist_pat),
        .scan_shift(scan_shift), .sdi(sdi), .sdo(sdo), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .err_pulse(err_pulse), .bist_error(bist_error), .err_addr(err_addr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM with per-address XOR fault masks and LAT-cycle read latency
    bit [DW-1:0] sram  [512];
    bit [DW-1:0] fault [512];
    bit [DW-1:0] rq    [LAT];

    always @(posedge clk) begin
        if (mem_cs && mem_we) sram[mem_addr] <= mem_wdata;
        for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
        rq[0] <= (mem_cs && !mem_we) ? (sram[mem_addr] ^ fault[mem_addr]) : '0;
    end
    assign mem_rdata = rq[LAT-1];

    // Reference model: abstract memory contents plus a list of pending read verdicts
    typedef struct { int cmp; bit [AW-1:0] addr; bit fail; } rd_t;
    rd_t          pend[$];
    bit [DW-1:0]  mmem [512];
    bit           m_cs, m_we, m_pulse, m_err;
    bit [AW-1:0]  m_addr, m_eaddr;
    bit [DW-1:0]  m_wdata;
    bit [CW-1:0]  m_cnt;
    int           cyc;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic check_all();
        chk("mem_cs",     32'(mem_cs),     32'(m_cs));
        chk("mem_we",     32'(mem_we),     32'(m_we));
        chk("mem_addr",   32'(mem_addr),   32'(m_addr));
        chk("mem_wdata",  mem_wdata,       m_wdata);
        chk("err_pulse",  32'(err_pulse),  32'(m_pulse));
        chk("bist_error", 32'(bist_error), 32'(m_err));
        chk("err_addr",   32'(err_addr),   32'(m_eaddr));
        chk("err_cnt",    32'(err_cnt),    32'(m_cnt));
    endtask

    task automatic model_clear();
        m_cs = 0; m_we = 0; m_pulse = 0; m_err = 0;
        m_addr = '0; m_eaddr = '0; m_wdata = '0; m_cnt = '0;
        pend.delete();
    endtask

    // One clock cycle: drive inputs, predict, clock, compare
    task automatic step(input bit r, input bit rd, input bit wr, input bit inv,
                        input bit [AW-1:0] a, input bit [DW-1:0] p,
                        input bit sh, input bit sd);
        bit          issue;
        bit [DW-1:0] e;
        bit [AW+CW:0] ch;
        rd_t         keep[$];
        run = r; op_read = rd; op_write = wr; op_invert = inv;
        bist_addr = a; bist_pat = p; scan_shift = sh; sdi = sd;
        chk("sdo", 32'(sdo), 32'(m_eaddr[0]));

        issue   = r && !sh && (rd || wr);
        e       = inv ? ~p : p;
        m_pulse = 0;
        keep    = {};
        foreach (pend[i]) begin
            if (pend[i].cmp == cyc) begin
                if (!sh && pend[i].fail) begin
                    m_pulse = 1;
                    if (!m_err) m_eaddr = pend[i].addr;
                    m_err = 1;
                    if (m_cnt != 4'hF) m_cnt = m_cnt + 1;
                end
            end else if (!sh) begin
                keep.push_back(pend[i]);
            end
        end
        pend = keep;
        if (sh) begin
            ch = {m_err, m_cnt, m_eaddr};
            ch = {sd, ch[AW+CW:1]};
            {m_err, m_cnt, m_eaddr} = ch;
        end
        m_cs = issue;
        m_we = issue && wr && !rd;
        if (issue) begin
            m_addr  = a;
            m_wdata = e;
            if (m_we) mmem[a] = e;
            if (rd) pend.push_back('{cmp: cyc + 1 + LAT, addr: a, fail: ((mmem[a] ^ fault[a]) != e)});
        end

        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic scan(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, 1, 0);
    endtask

    // Asynchronous reset asserted away from the clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        run = 0; op_read = 0; op_write = 0; scan_shift = 0;
        #1;
        model_clear();
        check_all();
        chk("rst_sdo", 32'(sdo), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        cyc = 0;
        rst_n = 1'b0;
        run = 0; op_read = 0; op_write = 0; op_invert = 0; scan_shift = 0; sdi = 0;
        bist_addr = '0; bist_pat = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Write-then-read pass
        step(1, 0, 1, 0, 9'h010, 32'hA5A5A5A5, 0, 0);
        chk("t1_we_wr", 32'(mem_we), 32'd1);
        step(1, 1, 0, 0, 9'h010, 32'hA5A5A5A5, 0, 0);
        chk("t1_we_rd", 32'(mem_we), 32'd0);
        idle(LAT + 2);
        chk("t1_err", 32'(bist_error), 32'd0);
        chk("t1_cnt", 32'(err_cnt), 32'd0);

        // Invert path: clean read passes, inverted-returning address fails
        step(1, 0, 1, 1, 9'h011, 32'h0000FFFF, 0, 0);
        chk("t2_wdata", mem_wdata, 32'hFFFF0000);
        step(1, 1, 0, 1, 9'h011, 32'h0000FFFF, 0, 0);
        idle(LAT + 2);
        chk("t2_pass", 32'(bist_error), 32'd0);
        fault[9'h012] = 32'hFFFFFFFF;
        step(1, 0, 1, 1, 9'h012, 32'h0000FFFF, 0, 0);
        step(1, 1, 0, 1, 9'h012, 32'h0000FFFF, 0, 0);
        idle(LAT + 2);
        chk("t2_fail", 32'(bist_error), 32'd1);

        // Latency: single bit-5 corruption at 0x1F8
        do_reset();
        fault[9'h1F8] = 32'h00000020;
        step(1, 0, 1, 0, 9'h1F8, 32'h12345678, 0, 0);
        step(1, 1, 0, 0, 9'h1F8, 32'h12345678, 0, 0);
        idle(LAT);
        chk("t3_no_pulse_yet", 32'(err_pulse), 32'd0);
        idle(1);
        chk("t3_pulse", 32'(err_pulse), 32'd1);
        idle(1);
        chk("t3_pulse_one", 32'(err_pulse), 32'd0);
        chk("t3_addr", 32'(err_addr), 32'h1F8);
        chk("t3_cnt", 32'(err_cnt), 32'd1);

        // Scan readout with zero fill clears the results
        scan(1 + CW + AW);
        chk("t5_err", 32'(bist_error), 32'd0);
        chk("t5_cnt", 32'(err_cnt), 32'd0);
        chk("t5_addr", 32'(err_addr), 32'd0);

        // First-fail capture and counter saturation over back-to-back failures
        for (int i = 0; i < 20; i++) fault[9'h020 + i] = 32'h1 << i;
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 9'(9'h020 + i), 32'hC3C3C3C3, 0, 0);
        idle(LAT + 2);
        chk("t4_addr", 32'(err_addr), 32'h020);
        chk("t4_cnt", 32'(err_cnt), 32'hF);
        chk("t4_err", 32'(bist_error), 32'd1);
        scan(1 + CW + AW);

        // Scan abort of an in-flight failing read
        fault[9'h040] = 32'h80000000;
        step(1, 1, 0, 0, 9'h040, 32'h0, 0, 0);
        idle(1);
        scan(2);
        chk("t6_cs", 32'(mem_cs), 32'd0);
        idle(LAT + 2);
        chk("t6_scan_err", 32'(bist_error), 32'd0);

        // Reset abort of an in-flight failing read
        step(1, 1, 0, 0, 9'h040, 32'h0, 0, 0);
        idle(1);
        do_reset();
        idle(LAT + 2);
        chk("t6_rst_err", 32'(bist_error), 32'd0);

        // Randomised traffic over a small address range with random faults and scans
        fault[3]  = $urandom | 32'h1;
        fault[7]  = 32'h1 << $urandom_range(0, 31);
        fault[11] = $urandom | 32'h100;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                 9'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) != 0) ? 32'h5A5A0F0F : $urandom,
                 $urandom_range(0, 15) == 0, 1'($urandom));
        end
        idle(LAT + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
